// File: rtl/redmule_tile_eoc_axi_writer_if.sv
// AXI4 channel bundle between the EOC writer (master) and the L2 mailbox (slave).
// The AR/R group is only exercised when REDMULE_TILE_EOC_READBACK_EN is defined.
`timescale 1ns/1ps
interface redmule_tile_eoc_axi_writer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1
);
    logic                aw_valid_o;
    logic                aw_ready_i;
    logic [ID_W-1:0]     aw_id_o;
    logic [ADDR_W-1:0]   aw_addr_o;
    logic [7:0]          aw_len_o;
    logic [2:0]          aw_size_o;
    logic [1:0]          aw_burst_o;
    logic                w_valid_o;
    logic                w_ready_i;
    logic [DATA_W-1:0]   w_data_o;
    logic [DATA_W/8-1:0] w_strb_o;
    logic                w_last_o;
    logic                b_valid_i;
    logic                b_ready_o;
    logic [1:0]          b_resp_i;
    logic                ar_valid_o;
    logic                ar_ready_i;
    logic [ID_W-1:0]     ar_id_o;
    logic [ADDR_W-1:0]   ar_addr_o;
    logic                r_valid_i;
    logic                r_ready_o;
    logic [DATA_W-1:0]   r_data_i;
    logic [1:0]          r_resp_i;

    modport master (
        output aw_valid_o, aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
               w_valid_o, w_data_o, w_strb_o, w_last_o, b_ready_o,
               ar_valid_o, ar_id_o, ar_addr_o, r_ready_o,
        input  aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
               ar_ready_i, r_valid_i, r_data_i, r_resp_i
    );

    modport slave (
        input  aw_valid_o, aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
               w_valid_o, w_data_o, w_strb_o, w_last_o, b_ready_o,
               ar_valid_o, ar_id_o, ar_addr_o, r_ready_o,
        output aw_ready_i, w_ready_i, b_valid_i, b_resp_i,
               ar_ready_i, r_valid_i, r_data_i, r_resp_i
    );
endinterface

// File: rtl/redmule_tile_eoc_axi_writer.sv
// Single-shot AXI4 writer of the tile's end-of-computation word, with retry on error responses.
// Optional readback verification via macro REDMULE_TILE_EOC_READBACK_EN; rst_n is active-HIGH async.
`timescale 1ns/1ps
module redmule_tile_eoc_axi_writer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 1,
    parameter logic [ADDR_W-1:0] EOC_ADDR  = ADDR_W'(32'h2C03_0000),
    parameter int unsigned       MAX_RETRY = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                eoc_valid_i,
    input  logic [31:0]                         eoc_code_i,
    output logic                                eoc_ready_o,
    redmule_tile_eoc_axi_writer_if.master       axi,
    output logic                                done_o,
    output logic                                err_o
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned LANE  = int'(EOC_ADDR[OFS_W-1:0]) / 4;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  BURST_INCR = 2'b01;

`ifdef REDMULE_TILE_EOC_READBACK_EN
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, DONE, FAIL} state_t;
    localparam state_t AFTER_B = READ;
`else
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, DONE, FAIL} state_t;
    localparam state_t AFTER_B = DONE;
`endif

    state_t      state_q, state_d;
    logic [31:0] word_q;
    logic [3:0]  retry_q;
    logic        aw_done_q, w_done_q;
    logic        aw_hs, w_hs, retry_ok, rewrite;
    logic        unused;

    assign aw_hs    = axi.aw_valid_o && axi.aw_ready_i;
    assign w_hs     = axi.w_valid_o && axi.w_ready_i;
    assign retry_ok = retry_q < 4'(MAX_RETRY);

    always_comb begin
        state_d = state_q;
        rewrite = 1'b0;
        unique case (state_q)
            IDLE:   if (eoc_valid_i) state_d = WRITE;
            WRITE:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
            WAIT_B: if (axi.b_valid_i) begin
                if (axi.b_resp_i == RESP_OKAY) begin
                    state_d = AFTER_B;
                end else begin
                    rewrite = retry_ok;
                    state_d = retry_ok ? WRITE : FAIL;
                end
            end
`ifdef REDMULE_TILE_EOC_READBACK_EN
            READ:   if (axi.ar_ready_i) state_d = WAIT_R;
            WAIT_R: if (axi.r_valid_i) begin
                if (axi.r_resp_i == RESP_OKAY && axi.r_data_i[LANE*32 +: 32] == word_q) begin
                    state_d = DONE;
                end else begin
                    rewrite = retry_ok;
                    state_d = retry_ok ? WRITE : FAIL;
                end
            end
`endif
            DONE, FAIL: state_d = state_q;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            retry_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // LSB forced high so the mailbox poller never mistakes a valid code for "empty"
            if (eoc_ready_o && eoc_valid_i) word_q <= {eoc_code_i[30:0], 1'b1};
            if (rewrite) retry_q <= retry_q + 4'd1;
            if (state_q != WRITE) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                aw_done_q <= aw_done_q || aw_hs;
                w_done_q  <= w_done_q || w_hs;
            end
        end
    end

    assign eoc_ready_o    = (state_q == IDLE) && !rst_n;
    assign done_o         = (state_q == DONE);
    assign err_o          = (state_q == FAIL);

    assign axi.aw_valid_o = (state_q == WRITE) && !aw_done_q;
    assign axi.aw_id_o    = '0;
    assign axi.aw_addr_o  = EOC_ADDR;
    assign axi.aw_len_o   = 8'd0;
    assign axi.aw_size_o  = 3'(OFS_W);
    assign axi.aw_burst_o = BURST_INCR;
    assign axi.w_valid_o  = (state_q == WRITE) && !w_done_q;
    assign axi.w_data_o   = DATA_W'(word_q) << (LANE * 32);
    assign axi.w_strb_o   = NB'(4'hF) << (LANE * 4);
    assign axi.w_last_o   = 1'b1;
    assign axi.b_ready_o  = (state_q == WRITE) || (state_q == WAIT_B);
    assign axi.ar_id_o    = '0;
    assign axi.ar_addr_o  = EOC_ADDR;
`ifdef REDMULE_TILE_EOC_READBACK_EN
    assign axi.ar_valid_o = (state_q == READ);
    assign axi.r_ready_o  = (state_q == WAIT_R);
`else
    assign axi.ar_valid_o = 1'b0;
    assign axi.r_ready_o  = !rst_n;
`endif

    assign unused = ^{eoc_code_i[31], axi.ar_ready_i, axi.r_valid_i, axi.r_data_i, axi.r_resp_i};

    // A write response is only legal once both AW and W of the attempt have handshaken
    b_before_aw_w: assert property (@(posedge clk) disable iff (rst_n)
        !(state_q == WRITE && axi.b_valid_i));
endmodule
